// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding (BOOT / RUN / HALT)
//   NOP_WORD      : default instruction word used for pipeline bubbles
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : capture i_instr / i_pc_plus1 as a valid instruction
//   i_flush      : replace contents with a bubble (takes priority over load)
//   i_instr      : instruction word from memory
//   i_pc_plus1   : PC+1 of that instruction
//   o_instr, o_pc_plus1, o_valid : registered IF/ID contents
// With neither load nor flush the register holds (stall).
module instr_fetch_if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus1,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus1,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus1;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus1 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      // A bubble looks exactly like the reset contents.
      r_instr    <= NOP_INSTR;
      r_pc_plus1 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus1 <= i_pc_plus1;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus1 = r_pc_plus1;
  assign o_valid    = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the word-indexed PC, addresses INSTR_MEM
// combinationally and captures the returned word into the IF/ID register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_addr/imem_data : combinational instruction memory interface
//   stall               : hold PC, IF/ID and fetch counter
//   redirect/redirect_pc: load PC and flush IF/ID (wins over stall)
//   halt                : sticky stop, left only through reset
//   if_id_*             : IF/ID register contents for decode
//   fetch_cnt           : saturating count of valid fetches
//   fetch_fault         : sticky, PC left 0..MEM_DEPTH-1
//   halted              : FSM is in HALT
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_DEPTH = 129,
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc_plus1,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             fetch_fault,
  output logic             halted
);

  localparam logic [31:0] LP_DEPTH = 32'(MEM_DEPTH);

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic             r_halted;

  logic        w_run;
  logic        w_oor;
  logic        w_load;
  logic        w_flush;
  logic [31:0] w_pc_plus1;

  assign w_run      = (r_state == ST_RUN);
  assign w_oor      = (r_pc >= LP_DEPTH);
  assign w_pc_plus1 = r_pc + 32'd1;

  // Halt and out-of-range flush even without redirect; BOOT keeps the
  // reset bubble in place so decode sees exactly one bubble after reset.
  assign w_flush = (r_state == ST_BOOT) | (w_run & (halt | w_oor | redirect));
  assign w_load  = w_run & ~halt & ~w_oor & ~redirect & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_oor) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end else if (redirect) begin
            r_pc <= redirect_pc;
          end else if (!stall) begin
            r_pc <= w_pc_plus1;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HALT: r_halted <= 1'b1;
        default: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  instr_fetch_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (imem_data),
    .i_pc_plus1 (w_pc_plus1),
    .o_instr    (if_id_instr),
    .o_pc_plus1 (if_id_pc_plus1),
    .o_valid    (if_id_valid)
  );

  assign imem_addr   = r_pc;
  assign fetch_cnt   = r_cnt;
  assign fetch_fault = r_fault;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the stimulus process advances a
// behavioural model and queues the expected post-edge outputs; the monitor
// pops one entry after every rising edge and compares.
module tb_instr_fetch;

  localparam int          MEM_DEPTH = 129;
  localparam int          CNT_W     = 4;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             halt;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc_plus1;
  logic             if_id_valid;
  logic [CNT_W-1:0] fetch_cnt;
  logic             fetch_fault;
  logic             halted;

  instr_fetch #(
    .RESET_PC  (32'd0),
    .MEM_DEPTH (MEM_DEPTH),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .fetch_cnt      (fetch_cnt),
    .fetch_fault    (fetch_fault),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents, random per run.
  logic [31:0] mem [0:MEM_DEPTH-1];
  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr < 32'(MEM_DEPTH)) imem_data = mem[imem_addr[7:0]];
  end

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      instr;
    logic [31:0]      pcp1;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic             fault;
    logic             halted;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pcp1;
  logic        m_valid, m_fault, m_halted, m_boot;
  int          m_cnt;

  function automatic exp_t model_snapshot();
    exp_t e;
    e.addr   = m_pc;
    e.instr  = m_instr;
    e.pcp1   = m_pcp1;
    e.valid  = m_valid;
    e.cnt    = CNT_W'(m_cnt);
    e.fault  = m_fault;
    e.halted = m_halted;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    logic bad;
    bad = 1'b0;
    vectors++;
    if (imem_addr !== e.addr) begin
      $display("FAIL %s imem_addr got %h want %h", name, imem_addr, e.addr); bad = 1'b1;
    end
    if (if_id_instr !== e.instr) begin
      $display("FAIL %s if_id_instr got %h want %h", name, if_id_instr, e.instr); bad = 1'b1;
    end
    if (if_id_pc_plus1 !== e.pcp1) begin
      $display("FAIL %s if_id_pc_plus1 got %h want %h", name, if_id_pc_plus1, e.pcp1); bad = 1'b1;
    end
    if (if_id_valid !== e.valid) begin
      $display("FAIL %s if_id_valid got %b want %b", name, if_id_valid, e.valid); bad = 1'b1;
    end
    if (fetch_cnt !== e.cnt) begin
      $display("FAIL %s fetch_cnt got %0d want %0d", name, fetch_cnt, e.cnt); bad = 1'b1;
    end
    if (fetch_fault !== e.fault) begin
      $display("FAIL %s fetch_fault got %b want %b", name, fetch_fault, e.fault); bad = 1'b1;
    end
    if (halted !== e.halted) begin
      $display("FAIL %s halted got %b want %b", name, halted, e.halted); bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pcp1 = 32'd0; m_valid = 1'b0;
    m_cnt = 0; m_fault = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_bubble();
    m_instr = NOP; m_pcp1 = 32'd0; m_valid = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, advance the model by one
  // rising edge, queue the expectation, then wait for the next falling edge.
  task automatic step(input logic h, input logic st, input logic rd, input logic [31:0] rpc);
    halt = h; stall = st; redirect = rd; redirect_pc = rpc;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halted) begin
      if (h) begin
        m_halted = 1'b1; model_bubble();
      end else if (m_pc >= 32'(MEM_DEPTH)) begin
        m_halted = 1'b1; m_fault = 1'b1; model_bubble();
      end else if (rd) begin
        m_pc = rpc; model_bubble();
      end else if (!st) begin
        m_instr = mem[m_pc[7:0]];
        m_pcp1  = m_pc + 32'd1;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    exp_q.push_back(model_snapshot());
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge and checks the outputs react at once,
  // before any clock edge, then releases reset at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0; halt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    #1;
    model_reset();
    check("async_reset", model_snapshot());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", exp_q.pop_front());
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    rst_n = 1'b0; halt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    model_reset();
    @(negedge clk);

    // Plain sequential fetch, then a 3-cycle stall at PC=4.
    do_reset();
    run(5);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    run(3);

    // Redirect together with stall: redirect wins.
    step(1'b0, 1'b1, 1'b1, 32'd20);
    run(3);

    // Last legal word, then out of range; redirects ignored while halted.
    step(1'b0, 1'b0, 1'b1, 32'd128);
    run(2);
    step(1'b0, 1'b0, 1'b1, 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'd5);
    run(2);

    // Halt and redirect together at PC=7, then reset while halted.
    do_reset();
    run(8);
    step(1'b1, 1'b0, 1'b1, 32'd50);
    step(1'b0, 1'b0, 1'b1, 32'd9);
    run(2);
    do_reset();

    // Counter saturation over 20 fetches.
    run(21);

    // Far out-of-range redirect near the 32-bit wrap point.
    do_reset();
    run(3);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run(3);

    // Randomized segments.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        logic        h, st, rd;
        logic [31:0] rpc;
        h   = ($urandom_range(0, 79) == 0);
        st  = ($urandom_range(0, 3) == 0);
        rd  = ($urandom_range(0, 7) == 0);
        rpc = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 135));
        step(h, st, rd, rpc);
      end
    end

    halt = 1'b0; stall = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain %0d expectations left unchecked, want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
